// File: rtl/mem_dcache_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_dcache_if_pkg
// Shared definitions for the pipeline-to-data-cache bridge:
//   - access size encodings (byte / half / word; 2'b11 is illegal)
//   - FSM state encoding
//   - helpers for alignment checking and store lane formatting
// ---------------------------------------------------------------------------
package mem_dcache_if_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // A request is legal only for a defined size whose natural alignment
    // is met by the low address bits.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~off[0];
            SIZE_WORD: ok = (off == 2'b00);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-enable pattern for a store of the given size at byte offset off.
    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << off;
            SIZE_HALF: strb = 4'b0011 << off;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate narrow store data across all lanes so the strobe alone
    // selects which bytes the cache writes.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SIZE_BYTE: d = {4{wdata[7:0]}};
            SIZE_HALF: d = {2{wdata[15:0]}};
            default:   d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_dcache_if_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load formatter: shifts the cache word down by the byte
// offset and then sign- or zero-extends byte and half accesses.
// Ports:
//   i_rdata  [31:0] raw word from the data cache
//   i_off    [1:0]  byte offset of the access within the word
//   i_size   [1:0]  access size (byte / half / word)
//   i_sext          1 = sign-extend narrow loads, 0 = zero-extend
//   o_result [31:0] formatted load value
// ---------------------------------------------------------------------------
module load_align
    import mem_dcache_if_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    output logic [31:0] o_result
);

    logic [31:0] w_shifted;
    logic [3:0]  w_lane_sel;

    // Each output byte lane picks source lane (gi + off); lanes beyond the
    // top of the word read as zero, matching a logical right shift.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [2:0] w_src;
            assign w_src           = 3'(gi) + {1'b0, i_off};
            assign w_lane_sel[gi]  = (w_src < 3'd4);
            assign w_shifted[8*gi +: 8] = w_lane_sel[gi] ? i_rdata[8*w_src[1:0] +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        o_result = w_shifted;
        case (i_size)
            SIZE_BYTE: o_result = {{24{i_sext & w_shifted[7]}},  w_shifted[7:0]};
            SIZE_HALF: o_result = {{16{i_sext & w_shifted[15]}}, w_shifted[15:0]};
            default:   o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_dcache_if.sv
// ---------------------------------------------------------------------------
// mem_dcache_if
// Bridge between the pipeline memory stage and a valid/addr_ok/ready style
// data cache. One access is in flight at a time; the pipeline is stalled
// from acceptance until the access completes.
// Ports (pipeline side):
//   mem_req_valid/we/size/sext/addr/wdata  request from the memory stage
//   mem_flush                              cancel the in-flight access
//   mem_stall                              hold the pipeline
//   mem_resp_valid / mem_resp_rdata        completion pulse and load data
//   mem_ale                                misaligned/illegal request
// Ports (cache side):
//   DCache_valid/op/addr/wstrb/wdata       request to the cache
//   DCache_addr_ok                         cache accepted the request
//   DCache_ready / DCache_rdata            data returned / write done
// clk rising edge; rst asynchronous, active low.
// ---------------------------------------------------------------------------
module mem_dcache_if
    import mem_dcache_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_req_valid,
    input  logic        mem_req_we,
    input  logic [1:0]  mem_req_size,
    input  logic        mem_req_sext,
    input  logic [31:0] mem_req_addr,
    input  logic [31:0] mem_req_wdata,
    input  logic        mem_flush,

    output logic        mem_stall,
    output logic        mem_resp_valid,
    output logic [31:0] mem_resp_rdata,
    output logic        mem_ale,

    output logic        DCache_valid,
    output logic        DCache_op,
    output logic [31:0] DCache_addr,
    output logic [3:0]  DCache_wstrb,
    output logic [31:0] DCache_wdata,
    input  logic        DCache_addr_ok,
    input  logic        DCache_ready,
    input  logic [31:0] DCache_rdata
);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_op;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_cancel;
    logic [31:0] r_rdata;

    logic        w_aligned;
    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_load_result;

    assign w_aligned = is_aligned(mem_req_size, mem_req_addr[1:0]);
    // Acceptance only in IDLE; a flush in the same cycle wins over the request.
    assign w_accept  = (r_state == ST_IDLE) && mem_req_valid && !mem_flush && w_aligned;

    load_align u_load_align (
        .i_rdata  (DCache_rdata),
        .i_off    (r_addr[1:0]),
        .i_size   (r_size),
        .i_sext   (r_sext),
        .o_result (w_load_result)
    );

    // -----------------------------------------------------------------------
    // State register and request/response capture
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_op     <= 1'b0;
            r_size   <= 2'b00;
            r_sext   <= 1'b0;
            r_addr   <= 32'h0;
            r_wstrb  <= 4'h0;
            r_wdata  <= 32'h0;
            r_cancel <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            r_state <= w_state_next;

            if (w_accept) begin
                r_op    <= mem_req_we;
                r_size  <= mem_req_size;
                r_sext  <= mem_req_sext;
                r_addr  <= mem_req_addr;
                r_wstrb <= store_strobe(mem_req_size, mem_req_addr[1:0]);
                r_wdata <= store_data(mem_req_size, mem_req_wdata);
            end

            // Stores report zero so the pipeline never sees stale load data.
            if (w_capture) begin
                r_rdata <= r_op ? 32'h0 : w_load_result;
            end

            // DONE always leads to IDLE, so clearing here clears on IDLE entry.
            if (r_state == ST_DONE) begin
                r_cancel <= 1'b0;
            end else if (((r_state == ST_REQ) || (r_state == ST_WAIT)) && mem_flush) begin
                r_cancel <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_capture      = 1'b0;
        DCache_valid   = 1'b0;
        mem_stall      = 1'b0;
        mem_ale        = 1'b0;
        mem_resp_valid = 1'b0;

        case (r_state)
            ST_IDLE: begin
                mem_stall = w_accept;
                mem_ale   = mem_req_valid && !mem_flush && !w_aligned;
                if (w_accept) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                DCache_valid = 1'b1;
                mem_stall    = 1'b1;
                // A flush does not withdraw the request: the cache may already
                // be committed, so the handshake runs to completion.
                if (DCache_addr_ok) begin
                    if (DCache_ready) begin
                        w_state_next = ST_DONE;
                        w_capture    = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                if (DCache_ready) begin
                    w_state_next = ST_DONE;
                    w_capture    = 1'b1;
                end
            end
            ST_DONE: begin
                mem_resp_valid = !r_cancel && !mem_flush;
                w_state_next   = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_resp_rdata = mem_resp_valid ? r_rdata : 32'h0;
    assign DCache_op      = r_op;
    assign DCache_addr    = r_addr;
    assign DCache_wstrb   = r_wstrb;
    assign DCache_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_dcache_if.sv
// ---------------------------------------------------------------------------
// tb_mem_dcache_if
// Directed bench for mem_dcache_if. A transaction task walks each access
// cycle by cycle, acting as the cache and setting the outputs the design
// must show in that cycle; expected request/response values come from
// byte-lane arithmetic in the model functions below. A single compare
// process checks every cycle on the falling edge. Literal checks after
// selected transactions pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_dcache_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [1:0]  mem_req_size;
    logic        mem_req_sext;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_flush;
    logic        mem_stall;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_ale;
    logic        DCache_valid;
    logic        DCache_op;
    logic [31:0] DCache_addr;
    logic [3:0]  DCache_wstrb;
    logic [31:0] DCache_wdata;
    logic        DCache_addr_ok;
    logic        DCache_ready;
    logic [31:0] DCache_rdata;

    mem_dcache_if dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_we     (mem_req_we),
        .mem_req_size   (mem_req_size),
        .mem_req_sext   (mem_req_sext),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_flush      (mem_flush),
        .mem_stall      (mem_stall),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_ale        (mem_ale),
        .DCache_valid   (DCache_valid),
        .DCache_op      (DCache_op),
        .DCache_addr    (DCache_addr),
        .DCache_wstrb   (DCache_wstrb),
        .DCache_wdata   (DCache_wdata),
        .DCache_addr_ok (DCache_addr_ok),
        .DCache_ready   (DCache_ready),
        .DCache_rdata   (DCache_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expectations for the current cycle, set by the transaction task.
    logic        chk_en = 1'b0;
    logic        exp_zero, exp_stall, exp_ale, exp_dvalid, exp_resp, exp_op, exp_store;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;

    // Observations collected by the compare process.
    int          dvalid_cycles = 0;
    int          resp_pulses   = 0;
    int          ale_pulses    = 0;
    logic [3:0]  seen_wstrb;
    logic [31:0] seen_wdata;
    logic        seen_op;
    logic [31:0] seen_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp_v);
        end
    endtask

    // ---------------- model: byte-lane view of the access rules -------------
    function automatic int m_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic m_aligned(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b11) return 1'b0;
        return (int'(off) % m_bytes(size)) == 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s;
        int n;
        n = m_bytes(size);
        for (int i = 0; i < 4; i++) s[i] = (i >= int'(off)) && (i < int'(off) + n);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        int n;
        n = m_bytes(size);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % n) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic sext,
                                           input logic [1:0] off, input logic [31:0] rd);
        logic [63:0] v;
        logic [7:0]  b;
        int n;
        n = m_bytes(size);
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            b = rd[8*(int'(off) + i) +: 8];
            v = v | (64'(b) << (8*i));
        end
        if (sext && n < 4 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        return v[31:0];
    endfunction

    // ---------------- compare process ---------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_stall",      32'(mem_stall),      32'(exp_stall));
            chk("mem_ale",        32'(mem_ale),        32'(exp_ale));
            chk("DCache_valid",   32'(DCache_valid),   32'(exp_dvalid));
            chk("mem_resp_valid", 32'(mem_resp_valid), 32'(exp_resp));
            if (exp_dvalid) begin
                chk("DCache_addr", DCache_addr,     exp_addr);
                chk("DCache_op",   32'(DCache_op),  32'(exp_op));
                if (exp_store) begin
                    chk("DCache_wstrb", 32'(DCache_wstrb), 32'(exp_wstrb));
                    chk("DCache_wdata", DCache_wdata,      exp_wdata);
                end
            end
            if (exp_resp) chk("mem_resp_rdata", mem_resp_rdata, exp_rdata);
            if (exp_zero) begin
                chk("rst_DCache_addr",  DCache_addr,          32'h0);
                chk("rst_DCache_op",    32'(DCache_op),       32'h0);
                chk("rst_DCache_wstrb", 32'(DCache_wstrb),    32'h0);
                chk("rst_DCache_wdata", DCache_wdata,         32'h0);
                chk("rst_resp_rdata",   mem_resp_rdata,       32'h0);
            end
            if (DCache_valid) begin
                dvalid_cycles++;
                seen_wstrb = DCache_wstrb;
                seen_wdata = DCache_wdata;
                seen_op    = DCache_op;
            end
            if (mem_resp_valid) begin
                resp_pulses++;
                seen_rdata = mem_resp_rdata;
            end
            if (mem_ale) ale_pulses++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_stall  = 1'b0;
        exp_ale    = 1'b0;
        exp_dvalid = 1'b0;
        exp_resp   = 1'b0;
    endtask

    // One access. aok_dly: REQ cycles before addr_ok; rdy_dly: cycles after
    // addr_ok until ready (0 = same cycle). flush_at indexes REQ/WAIT cycles
    // (-1 = none). dummy_done presents a legal request during DONE, which
    // must not be taken.
    task automatic txn(input logic we, input logic [1:0] size, input logic sext,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int aok_dly, input int rdy_dly, input int flush_at,
                       input logic flush_idle, input logic flush_done, input logic dummy_done);
        logic ok;
        logic cancel;
        int   cyc;
        ok = m_aligned(size, addr[1:0]);
        // IDLE cycle: present request; stray cache strobes must be ignored.
        mem_req_valid  = 1'b1;
        mem_req_we     = we;
        mem_req_size   = size;
        mem_req_sext   = sext;
        mem_req_addr   = addr;
        mem_req_wdata  = wdata;
        mem_flush      = flush_idle;
        DCache_addr_ok = 1'b1;
        DCache_ready   = 1'b1;
        DCache_rdata   = 32'h5555_AAAA;
        idle_exp();
        exp_stall = ok && !flush_idle;
        exp_ale   = !ok && !flush_idle;
        tick();
        mem_req_valid  = 1'b0;
        mem_flush      = 1'b0;
        DCache_addr_ok = 1'b0;
        DCache_ready   = 1'b0;
        if (!ok || flush_idle) begin
            idle_exp();
            tick();
            return;
        end
        // Scramble request inputs: the cache request must come from registers.
        mem_req_addr  = 32'hFFFF_FFFF;
        mem_req_wdata = 32'h1357_9BDF;
        mem_req_size  = 2'b11;
        exp_addr  = addr;
        exp_op    = we;
        exp_store = we;
        exp_wstrb = m_strb(size, addr[1:0]);
        exp_wdata = m_wdata(size, wdata);
        cancel = 1'b0;
        cyc    = 0;
        for (int k = 0; k <= aok_dly; k++) begin
            idle_exp();
            exp_dvalid     = 1'b1;
            exp_stall      = 1'b1;
            DCache_addr_ok = (k == aok_dly);
            DCache_ready   = (k == aok_dly) && (rdy_dly == 0);
            DCache_rdata   = DCache_ready ? rdata : (32'hA5A5_5A5A ^ 32'(k));
            mem_flush      = (cyc == flush_at);
            if (mem_flush) cancel = 1'b1;
            tick();
            cyc++;
        end
        for (int j = 1; j <= rdy_dly; j++) begin
            idle_exp();
            exp_stall      = 1'b1;
            DCache_addr_ok = 1'b1;
            DCache_ready   = (j == rdy_dly);
            DCache_rdata   = DCache_ready ? rdata : (32'h0F0F_F0F0 ^ 32'(j));
            mem_flush      = (cyc == flush_at);
            if (mem_flush) cancel = 1'b1;
            tick();
            cyc++;
        end
        // DONE cycle
        idle_exp();
        DCache_addr_ok = 1'b0;
        DCache_ready   = 1'b0;
        DCache_rdata   = 32'h0;
        mem_flush      = flush_done;
        exp_resp       = !cancel && !flush_done;
        exp_rdata      = we ? 32'h0 : m_load(size, sext, addr[1:0], rdata);
        if (dummy_done) begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_size  = 2'b10;
            mem_req_addr  = 32'h0000_3000;
        end
        tick();
        mem_req_valid = 1'b0;
        mem_flush     = 1'b0;
        idle_exp();
    endtask

    int r0;

    initial begin
        rst = 1'b0;
        mem_req_valid = 0; mem_req_we = 0; mem_req_size = 0; mem_req_sext = 0;
        mem_req_addr = 0; mem_req_wdata = 0; mem_flush = 0;
        DCache_addr_ok = 0; DCache_ready = 0; DCache_rdata = 0;
        exp_op = 0; exp_store = 0; exp_addr = 0; exp_wdata = 0; exp_rdata = 0; exp_wstrb = 0;
        idle_exp();
        exp_zero = 1'b1;
        chk_en   = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        exp_zero = 1'b0;

        // Word load, addr_ok next cycle, ready two cycles later.
        r0 = resp_pulses;
        txn(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2, -1, 1'b0, 1'b0, 1'b1);
        $display("txn word load 0x1000 -> %h", seen_rdata);
        chk("wl_rdata", seen_rdata, 32'hDEAD_BEEF);
        chk("wl_resp_count", 32'(resp_pulses - r0), 32'd1);

        // Byte loads at offset 3, minimum latency then one wait cycle.
        txn(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 0, -1, 1'b0, 1'b0, 1'b0);
        $display("txn byte load sext 0x1003 -> %h", seen_rdata);
        chk("lb_sext", seen_rdata, 32'hFFFF_FF80);
        txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h8012_3456, 0, 1, -1, 1'b0, 1'b0, 1'b1);
        $display("txn byte load zext 0x1003 -> %h", seen_rdata);
        chk("lb_zext", seen_rdata, 32'h0000_0080);

        // Half store at offset 2.
        txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 1, 1, -1, 1'b0, 1'b0, 1'b0);
        $display("txn half store 0x2002 wstrb=%b wdata=%h", seen_wstrb, seen_wdata);
        chk("sh_wstrb", 32'(seen_wstrb), 32'h0000_000C);
        chk("sh_wdata", seen_wdata, 32'hABCD_ABCD);
        chk("sh_op", 32'(seen_op), 32'd1);
        chk("sh_rdata", seen_rdata, 32'h0);

        // Misaligned / illegal requests.
        r0 = dvalid_cycles;
        txn(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 32'h0, 0, 0, -1, 1'b0, 1'b0, 1'b0);
        $display("txn misaligned word 0x1002 ale_pulses=%0d", ale_pulses);
        txn(1'b0, 2'b01, 1'b0, 32'h0000_1001, 32'h0, 32'h0, 0, 0, -1, 1'b0, 1'b0, 1'b0);
        $display("txn misaligned half 0x1001 ale_pulses=%0d", ale_pulses);
        txn(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, 0, -1, 1'b0, 1'b0, 1'b0);
        $display("txn illegal size 0x0 ale_pulses=%0d", ale_pulses);
        chk("ale_no_dvalid", 32'(dvalid_cycles - r0), 32'd0);
        chk("ale_count", 32'(ale_pulses), 32'd3);

        // Flush in WAIT, then a normal access.
        r0 = resp_pulses;
        txn(1'b0, 2'b10, 1'b0, 32'h0000_1100, 32'h0, 32'h1111_2222, 0, 2, 1, 1'b0, 1'b0, 1'b0);
        $display("txn load flushed in WAIT");
        chk("flush_wait_resp", 32'(resp_pulses - r0), 32'd0);
        txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0, -1, 1'b0, 1'b0, 1'b0);
        $display("txn half load sext 0x2002 -> %h", seen_rdata);
        chk("lh_sext", seen_rdata, 32'hFFFF_8001);

        // Flush in REQ (request still held), flush in DONE, flush in IDLE.
        r0 = resp_pulses;
        txn(1'b1, 2'b10, 1'b0, 32'h0000_3000, 32'h1234_5678, 32'h0, 2, 1, 0, 1'b0, 1'b0, 1'b0);
        $display("txn store flushed in REQ");
        txn(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 0, 0, -1, 1'b0, 1'b1, 1'b0);
        $display("txn load flushed in DONE");
        txn(1'b0, 2'b10, 1'b0, 32'h0000_3008, 32'h0, 32'h0, 0, 0, -1, 1'b1, 1'b0, 1'b0);
        $display("txn load blocked by flush in IDLE");
        chk("flush_resp_count", 32'(resp_pulses - r0), 32'd0);

        // addr_ok held low 5 cycles on a byte store at offset 1.
        r0 = dvalid_cycles;
        txn(1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_00E7, 32'h0, 5, 0, -1, 1'b0, 1'b0, 1'b1);
        $display("txn byte store 0x5001 wstrb=%b wdata=%h", seen_wstrb, seen_wdata);
        chk("sb_dvalid_cycles", 32'(dvalid_cycles - r0), 32'd6);
        chk("sb_wstrb", 32'(seen_wstrb), 32'h0000_0002);
        chk("sb_wdata", seen_wdata, 32'hE7E7_E7E7);

        // Reset pulse while waiting for data.
        r0 = resp_pulses;
        mem_req_valid = 1'b1; mem_req_we = 1'b0; mem_req_size = 2'b10; mem_req_sext = 1'b0;
        mem_req_addr = 32'h0000_4000; mem_flush = 1'b0;
        idle_exp(); exp_stall = 1'b1;
        tick();
        mem_req_valid = 1'b0; DCache_addr_ok = 1'b1;
        idle_exp(); exp_dvalid = 1'b1; exp_stall = 1'b1; exp_addr = 32'h0000_4000;
        exp_op = 1'b0; exp_store = 1'b0;
        tick();
        DCache_addr_ok = 1'b0;
        idle_exp(); exp_stall = 1'b1;
        tick();
        rst = 1'b0;
        idle_exp(); exp_zero = 1'b1;
        DCache_ready = 1'b1; DCache_rdata = 32'h1234_5678;
        tick();
        DCache_ready = 1'b0;
        tick();
        rst = 1'b1;
        exp_zero = 1'b0;
        chk("rst_no_resp", 32'(resp_pulses - r0), 32'd0);
        $display("txn reset in WAIT, resp_pulses delta=%0d", resp_pulses - r0);

        // First access right after reset release: word store.
        txn(1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'h89AB_CDEF, 32'h0, 0, 1, -1, 1'b0, 1'b0, 1'b0);
        $display("txn word store 0x6000 wstrb=%b wdata=%h", seen_wstrb, seen_wdata);
        chk("sw_wstrb", 32'(seen_wstrb), 32'h0000_000F);
        chk("sw_wdata", seen_wdata, 32'h89AB_CDEF);

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
